mem_hs_param: RTL and testbench



---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_array_1rw.sv | 19 +
 rtl/mem_hs_param.sv | 118 +++++++++++
 tb/tb_mem_hs_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types, default widths and byte-lane merge helper for the memory blocks
package mem_pkg;
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_e;
  localparam int DEF_BITS_DATA = 32;
  localparam int DEF_BITS_ADDR = 16;
  localparam int MAX_BITS = 1024;
  localparam int MAX_BE = MAX_BITS / 8;
  // Callers zero-extend into MAX_BITS and truncate the result back to their own width.
  function automatic logic [MAX_BITS-1:0] be_merge(input logic [MAX_BITS-1:0] old_w,
                                                   input logic [MAX_BITS-1:0] new_w,
                                                   input logic [MAX_BE-1:0] be);
    be_merge = old_w;
    for (int i = 0; i < MAX_BE; i++)
      if (be[i]) be_merge[8*i+:8] = new_w[8*i+:8];
  endfunction
endpackage

// File: rtl/mem_array_1rw.sv
// mem_array_1rw: single-port storage with byte-lane synchronous write and combinational read
module mem_array_1rw #(
  parameter int BITS_DATA = 32,
  parameter int DEPTH = 1024,
  parameter int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic [AW-1:0]          addr_i,
  input  logic                   we_i,
  input  logic [BITS_DATA/8-1:0] be_i,
  input  logic [BITS_DATA-1:0]   wdata_i,
  output logic [BITS_DATA-1:0]   rdata_o
);
  logic [BITS_DATA-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < BITS_DATA / 8; i++)
      if (we_i && be_i[i]) mem_q[addr_i][8*i+:8] <= wdata_i[8*i+:8];
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_hs_param.sv
// mem_hs_param: valid/ready data memory with byte enables, wait states and optional post-reset clear
module mem_hs_param
  import mem_pkg::*;
#(
  parameter int BITS_DATA = DEF_BITS_DATA,
  parameter int BITS_ADDR = DEF_BITS_ADDR,
  parameter int DEPTH = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [BITS_ADDR-1:0]   req_addr,
  input  logic [BITS_DATA-1:0]   req_wdata,
  input  logic [BITS_DATA/8-1:0] req_be,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [BITS_DATA-1:0]   resp_rdata,
  output logic                   resp_err,
  output logic                   busy
);
  localparam int BYTES = BITS_DATA / 8;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic write_q, req_ready_q, resp_err_q;
  logic [BITS_ADDR-1:0] addr_q;
  logic [BITS_DATA-1:0] wdata_q, resp_rdata_q;
  logic [BYTES-1:0] be_q;
  logic accept, enter_resp, in_range, op_write, arr_we;
  logic [BITS_ADDR-1:0] op_addr;
  logic [BITS_DATA-1:0] op_wdata, arr_rdata, arr_wdata, merged;
  logic [BYTES-1:0] op_be, arr_be;
  logic [AW-1:0] arr_addr;
  assign accept = req_valid && req_ready_q;
  // With zero wait states the access happens on the accept edge itself, so use the live request.
  assign op_write = state_q == S_IDLE ? req_write : write_q;
  assign op_addr = state_q == S_IDLE ? req_addr : addr_q;
  assign op_wdata = state_q == S_IDLE ? req_wdata : wdata_q;
  assign op_be = state_q == S_IDLE ? req_be : be_q;
  assign in_range = {1'b0, op_addr} < (BITS_ADDR + 1)'(DEPTH);
  assign merged = BITS_DATA'(be_merge(MAX_BITS'(arr_rdata), MAX_BITS'(op_wdata), MAX_BE'(op_be)));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    case (state_q)
      S_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = S_IDLE;
          ptr_d = '0;
        end
      end
      S_IDLE: if (accept) begin
        state_d = WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
        cnt_d = CW'(WAIT_CYCLES);
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_RESP;
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
    endcase
  end
  assign enter_resp = state_d == S_RESP && state_q != S_RESP;
  assign arr_we = state_q == S_CLEAR || (enter_resp && op_write && in_range);
  assign arr_addr = state_q == S_CLEAR ? ptr_q : op_addr[AW-1:0];
  assign arr_be = state_q == S_CLEAR ? '1 : op_be;
  assign arr_wdata = state_q == S_CLEAR ? '0 : op_wdata;
  mem_array_1rw #(.BITS_DATA(BITS_DATA), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk    (clk),
    .addr_i (arr_addr),
    .we_i   (arr_we),
    .be_i   (arr_be),
    .wdata_i(arr_wdata),
    .rdata_o(arr_rdata)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET != 0 ? S_CLEAR : S_IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      req_ready_q <= 1'b0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      req_ready_q <= state_d == S_IDLE;
      if (accept) begin
        write_q <= req_write;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        be_q <= req_be;
      end
      if (enter_resp) begin
        resp_rdata_q <= !in_range ? '0 : op_write ? merged : arr_rdata;
        resp_err_q <= !in_range;
      end
    end
  end
  assign req_ready = req_ready_q;
  assign resp_valid = state_q == S_RESP;
  assign resp_rdata = resp_rdata_q;
  assign resp_err = resp_err_q;
  assign busy = state_q == S_CLEAR;
endmodule

// File: tb/tb_mem_hs_param.sv
// tb_mem_hs_param: two DUT configurations checked against a word-array reference model
module tb_mem_hs_param;
  localparam int DEPTH = 16;
  localparam int W0 = 2;
  localparam int W1 = 3;
  logic clk = 1'b0;
  logic reset [2];
  logic req_valid [2];
  logic req_ready [2];
  logic req_write [2];
  logic [15:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [3:0] req_be [2];
  logic resp_valid [2];
  logic resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic resp_err [2];
  logic busy [2];
  logic [31:0] mdl [2][DEPTH];
  bit known [2][DEPTH];
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;

  mem_hs_param #(.BITS_DATA(32), .BITS_ADDR(16), .DEPTH(DEPTH), .WAIT_CYCLES(W0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .busy(busy[0]));
  mem_hs_param #(.BITS_DATA(32), .BITS_ADDR(16), .DEPTH(DEPTH), .WAIT_CYCLES(W1), .CLEAR_ON_RESET(0)) u1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .busy(busy[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    for (int i = 0; i < 4; i++) lane_mask[8*i+:8] = {8{be[i]}};
  endfunction

  function automatic int lat_exp(input int d);
    return (d == 0 ? W0 : W1) + 1;
  endfunction

  // Called right after the accept edge; lat counts cycles until resp_valid is seen.
  task automatic wait_resp(input int d, output int lat);
    lat = 1;
    @(negedge clk);
    while (!resp_valid[d] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_clear(input int d, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (busy[d] && n < 1000);
  endtask

  task automatic issue(input int d, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d] = a;
    req_wdata[d] = wd;
    req_be[d] = be;
    n = 0;
    while (!req_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
  endtask

  task automatic rtxn(input int d, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                      input logic [3:0] be);
    int lat;
    logic [31:0] ex;
    resp_ready[d] = 1'b1;
    issue(d, wr, a, wd, be);
    wait_resp(d, lat);
    chk("latency", 64'(lat), 64'(lat_exp(d)));
    if (a >= DEPTH) begin
      chk("oob_err", 64'(resp_err[d]), 64'd1);
      chk("oob_rdata", 64'(resp_rdata[d]), 64'd0);
    end else begin
      chk("err", 64'(resp_err[d]), 64'd0);
      ex = wr ? (mdl[d][a] & ~lane_mask(be)) | (wd & lane_mask(be)) : mdl[d][a];
      if (known[d][a]) chk(wr ? "write_rdata" : "read_rdata", 64'(resp_rdata[d]), 64'(ex));
      if (wr) begin
        mdl[d][a] = ex;
        known[d][a] = known[d][a] || be == 4'hF;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, lat;
    logic [31:0] held;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b0;
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d] = '0;
      req_wdata[d] = '0;
      req_be[d] = '0;
      resp_ready[d] = 1'b0;
    end
    #2 reset[0] = 1'b1;
    reset[1] = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready[0]), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata[0]), 64'd0);
    chk("rst_resp_err", 64'(resp_err[0]), 64'd0);
    chk("rst_busy_clr1", 64'(busy[0]), 64'd1);
    chk("rst_busy_clr0", 64'(busy[1]), 64'd0);
    chk("rst_req_ready_clr0", 64'(req_ready[1]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    wait_clear(0, n);
    chk("clear_cycles", 64'(n), 64'(DEPTH));
    chk("clr0_idle", 64'(req_ready[1]), 64'd1);
    for (int a = 0; a < DEPTH; a++) begin
      mdl[0][a] = '0;
      known[0][a] = 1'b1;
      known[1][a] = 1'b0;
    end
    rtxn(0, 1'b0, 16'd5, '0, 4'h0);
    rtxn(0, 1'b1, 16'd0, 32'h0000FFFF, 4'hF);
    rtxn(0, 1'b0, 16'd0, '0, 4'h0);
    rtxn(0, 1'b1, 16'd1, 32'h01005555, 4'hF);
    rtxn(0, 1'b1, 16'd1, 32'hAABBCCDD, 4'b0101);
    chk("merge_model", 64'(mdl[0][1]), 64'h01BB55DD);
    rtxn(0, 1'b0, 16'd1, '0, 4'h0);
    rtxn(0, 1'b1, 16'd7, 32'h77777777, 4'h0);
    rtxn(0, 1'b0, 16'h0010, '0, 4'h0);
    rtxn(0, 1'b1, 16'h0010, 32'hFFFFFFFF, 4'hF);
    rtxn(0, 1'b1, 16'hFFFF, 32'hFFFFFFFF, 4'hF);
    for (int a = 0; a < DEPTH; a++) rtxn(0, 1'b0, 16'(a), '0, 4'h0);
    for (int k = 0; k < 40; k++)
      rtxn(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, DEPTH + 1)), $urandom, 4'($urandom));
    // stalled response with the next request already waiting
    @(negedge clk);
    resp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0] = 16'd1;
    while (!req_ready[0]) @(negedge clk);
    @(posedge clk);
    #1 req_write[0] = 1'b1;
    req_addr[0] = 16'd2;
    req_wdata[0] = 32'hC0FFEE42;
    req_be[0] = 4'hF;
    wait_resp(0, lat);
    chk("stall_latency", 64'(lat), 64'(W0 + 1));
    held = resp_rdata[0];
    chk("stall_rdata", 64'(held), 64'(mdl[0][1]));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_hold_rdata", 64'(resp_rdata[0]), 64'(held));
      chk("stall_hold_valid", 64'(resp_valid[0]), 64'd1);
      chk("stall_no_ready", 64'(req_ready[0]), 64'd0);
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", 64'(resp_valid[0]), 64'd0);
    chk("post_hs_ready", 64'(req_ready[0]), 64'd1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    chk("second_accepted", 64'(req_ready[0]), 64'd0);
    wait_resp(0, lat);
    chk("second_latency", 64'(lat), 64'(W0 + 1));
    chk("second_rdata", 64'(resp_rdata[0]), 64'hC0FFEE42);
    mdl[0][2] = 32'hC0FFEE42;
    @(posedge clk);
    #1;
    rtxn(0, 1'b0, 16'd2, '0, 4'h0);
    // reset during WAIT on the clearing instance
    rtxn(0, 1'b1, 16'd5, 32'hDEADBEEF, 4'hF);
    rtxn(0, 1'b1, 16'd3, 32'h33331111, 4'hF);
    issue(0, 1'b1, 16'd3, 32'h12345678, 4'hF);
    @(negedge clk);
    reset[0] = 1'b1;
    #1;
    chk("mid_req_ready", 64'(req_ready[0]), 64'd0);
    chk("mid_resp_valid", 64'(resp_valid[0]), 64'd0);
    chk("mid_resp_rdata", 64'(resp_rdata[0]), 64'd0);
    chk("mid_resp_err", 64'(resp_err[0]), 64'd0);
    chk("mid_busy", 64'(busy[0]), 64'd1);
    @(negedge clk);
    reset[0] = 1'b0;
    wait_clear(0, n);
    chk("reclear_cycles", 64'(n), 64'(DEPTH));
    for (int a = 0; a < DEPTH; a++) mdl[0][a] = '0;
    rtxn(0, 1'b0, 16'd3, '0, 4'h0);
    rtxn(0, 1'b0, 16'd5, '0, 4'h0);
    // non-clearing instance: contents survive reset
    for (int a = 0; a < DEPTH; a++) rtxn(1, 1'b1, 16'(a), $urandom, 4'hF);
    for (int k = 0; k < 20; k++)
      rtxn(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, DEPTH + 1)), $urandom, 4'($urandom));
    rtxn(1, 1'b1, 16'd3, 32'h33331111, 4'hF);
    issue(1, 1'b1, 16'd3, 32'h12345678, 4'hF);
    @(negedge clk);
    reset[1] = 1'b1;
    #1;
    chk("mid1_req_ready", 64'(req_ready[1]), 64'd0);
    chk("mid1_resp_valid", 64'(resp_valid[1]), 64'd0);
    chk("mid1_resp_rdata", 64'(resp_rdata[1]), 64'd0);
    chk("mid1_busy", 64'(busy[1]), 64'd0);
    @(negedge clk);
    reset[1] = 1'b0;
    @(posedge clk);
    #1 chk("mid1_idle", 64'(req_ready[1]), 64'd1);
    rtxn(1, 1'b0, 16'd3, '0, 4'h0);
    for (int a = 0; a < DEPTH; a++) rtxn(1, 1'b0, 16'(a), '0, 4'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
